// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the PC sequencer.
//   pc_src_e   - source of the most recent PC update (reported on pc_src)
//   pc_state_e - sequencer FSM states
//   INSN_BYTES - fixed instruction size used for the sequential increment
package pc_pkg;

    localparam int unsigned INSN_BYTES = 4;

    typedef enum logic [2:0] {
        SRC_SEQ      = 3'd0,
        SRC_REDIRECT = 3'd1,
        SRC_RAS      = 3'd2,
        SRC_TRAP     = 3'd3,
        SRC_HOLD     = 3'd4
    } pc_src_e;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } pc_state_e;

endpackage

// File: rtl/return_stack.sv
// return_stack: circular return-address stack.
//   clk, reset (async, active-high)
//   push/push_data : write a return address on top
//   pop            : drop the top entry (ignored when empty)
//   flush          : discard all entries
//   top            : current top entry (only meaningful when !empty)
//   empty, full    : occupancy flags
// A push onto a full stack overwrites the oldest entry and the count
// saturates at RAS_DEPTH. push+pop together replaces the top in place.
module return_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int PW = $clog2(RAS_DEPTH);

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   top_idx, wr_idx;
    logic [PW:0]     count_q, count_d;
    logic            pop_eff, wr_en;

    // ptr_q points at the next free slot; the top lives one below it
    assign top_idx = ptr_q - PW'(1);
    assign top     = mem_q[top_idx];
    assign empty   = (count_q == '0);
    assign full    = (count_q == (PW+1)'(RAS_DEPTH));
    assign pop_eff = pop & ~empty;

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        if (flush) begin
            ptr_d   = '0;
            count_d = '0;
        end else if (push && pop_eff) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (push) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + PW'(1);
            if (!full) begin
                count_d = count_q + (PW+1)'(1);
            end
        end else if (pop_eff) begin
            ptr_d   = top_idx;
            count_d = count_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset; empty/count guard its contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with boot/run/halt control and an
// optional return-address stack (enabled by defining PC_SEQ_RAS_EN).
//   clk, reset (async, active-high)
//   stall, halt_req, resume            : flow control
//   redirect_valid/redirect_target     : taken branch or jump
//   trap/trap_target                   : exception or interrupt
//   is_call, is_ret                    : call/return hints for the RAS
//   pc, pc_plus4, fetch_valid, pc_misaligned, pc_src, ras_empty : status
//
// state   | meaning
// BOOT    | first cycle after reset, pc held, no fetch
// RUN     | fetching, pc advances per next-PC priority
// HALTED  | fetch stopped, pc frozen until resume or trap
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int          XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int          RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            halt_req,
    input  logic            resume,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_target,
    input  logic            is_call,
    input  logic            is_ret,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            fetch_valid,
    output logic            pc_misaligned,
    output logic [2:0]      pc_src,
    output logic            ras_empty
);

    pc_state_e       state_q, state_d;
    pc_src_e         src_q, src_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ras_top;
    logic            ras_push, ras_pop, ras_flush;
    logic            ras_hit;

    assign pc            = pc_q;
    assign pc_plus4      = pc_q + XLEN'(INSN_BYTES);
    assign pc_misaligned = |pc_q[1:0];
    assign pc_src        = src_q;
    assign ras_hit       = is_ret & ~ras_empty;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        src_d       = SRC_HOLD;
        fetch_valid = 1'b0;
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
        ras_flush   = 1'b0;
        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                fetch_valid = 1'b1;
                if (trap) begin
                    pc_d      = trap_target;
                    src_d     = SRC_TRAP;
                    ras_flush = 1'b1;
                end else if (halt_req) begin
                    state_d = ST_HALTED;
                end else if (redirect_valid || ras_hit || !stall) begin
                    // Any non-holding cycle applies the call/return hints.
                    ras_push = is_call;
                    ras_pop  = is_ret;
                    if (redirect_valid) begin
                        pc_d  = redirect_target;
                        src_d = SRC_REDIRECT;
                    end else if (ras_hit) begin
                        pc_d  = ras_top;
                        src_d = SRC_RAS;
                    end else begin
                        pc_d  = pc_plus4;
                        src_d = SRC_SEQ;
                    end
                end
            end
            ST_HALTED: begin
                if (trap) begin
                    state_d   = ST_RUN;
                    pc_d      = trap_target;
                    src_d     = SRC_TRAP;
                    ras_flush = 1'b1;
                end else if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
            src_q   <= SRC_HOLD;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            src_q   <= src_d;
        end
    end

`ifdef PC_SEQ_RAS_EN
    logic ras_full_unused;

    return_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .flush     (ras_flush),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full_unused)
    );
`else
    // Without a stack, returns fall through to sequential/redirect handling.
    logic unused_ras;

    assign ras_empty  = 1'b1;
    assign ras_top    = '0;
    assign unused_ras = ^{ras_push, ras_pop, ras_flush, is_call, RAS_DEPTH[0]};
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
    import pc_pkg::*;

    localparam int DEPTH = 4;
`ifdef PC_SEQ_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, halt_req, resume, redirect_valid, trap, is_call, is_ret;
    logic [31:0] redirect_target, trap_target;
    logic [31:0] pc, pc_plus4;
    logic        fetch_valid, pc_misaligned, ras_empty;
    logic [2:0]  pc_src;

    pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .stall(stall), .halt_req(halt_req), .resume(resume),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap(trap), .trap_target(trap_target), .is_call(is_call), .is_ret(is_ret),
        .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid),
        .pc_misaligned(pc_misaligned), .pc_src(pc_src), .ras_empty(ras_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        fv;
        pc_src_e     src;
        logic        empty;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    pc_state_e   m_state;
    logic [31:0] m_pc;
    pc_src_e     m_src;
    logic [31:0] m_ras[$];
    logic [31:0] ret_exp[5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = ST_BOOT;
        m_pc    = 32'h0;
        m_src   = SRC_HOLD;
        m_ras.delete();
        sb.delete();
    endtask

    task automatic model_next();
        logic [31:0] p4;
        logic        hit;
        p4  = m_pc + 32'd4;
        hit = RAS_ON && is_ret && (m_ras.size() > 0);
        case (m_state)
            ST_BOOT: begin
                m_state = ST_RUN;
                m_src   = SRC_HOLD;
            end
            ST_RUN: begin
                if (trap) begin
                    m_pc = trap_target; m_src = SRC_TRAP; m_ras.delete();
                end else if (halt_req) begin
                    m_state = ST_HALTED; m_src = SRC_HOLD;
                end else begin
                    if (redirect_valid)  begin m_pc = redirect_target; m_src = SRC_REDIRECT; end
                    else if (hit)        begin m_pc = m_ras[$];        m_src = SRC_RAS;      end
                    else if (stall)      begin                         m_src = SRC_HOLD;     end
                    else                 begin m_pc = p4;              m_src = SRC_SEQ;      end
                    if (RAS_ON && (redirect_valid || hit || !stall)) begin
                        if (is_ret && m_ras.size() > 0) void'(m_ras.pop_back());
                        if (is_call) begin
                            m_ras.push_back(p4);
                            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                        end
                    end
                end
            end
            default: begin
                if (trap) begin
                    m_state = ST_RUN; m_pc = trap_target; m_src = SRC_TRAP; m_ras.delete();
                end else if (resume) begin
                    m_state = ST_RUN; m_src = SRC_HOLD;
                end else begin
                    m_src = SRC_HOLD;
                end
            end
        endcase
    endtask

    task automatic step();
        exp_t e;
        model_next();
        e.pc = m_pc; e.fv = (m_state == ST_RUN); e.src = m_src; e.empty = (m_ras.size() == 0);
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        chk("pc", pc, e.pc);
        chk("pc_plus4", pc_plus4, e.pc + 32'd4);
        chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, e.fv});
        chk("pc_src", {29'b0, pc_src}, {29'b0, e.src});
        chk("ras_empty", {31'b0, ras_empty}, {31'b0, e.empty});
        chk("pc_misaligned", {31'b0, pc_misaligned}, {31'b0, |e.pc[1:0]});
    endtask

    task automatic drv(input logic st, input logic hr, input logic rs, input logic rv,
                       input logic [31:0] rt, input logic tr, input logic [31:0] tt,
                       input logic ca, input logic re);
        stall = st; halt_req = hr; resume = rs; redirect_valid = rv; redirect_target = rt;
        trap = tr; trap_target = tt; is_call = ca; is_ret = re;
        step();
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        stall = 0; halt_req = 0; resume = 0; redirect_valid = 0; redirect_target = 0;
        trap = 0; trap_target = 0; is_call = 0; is_ret = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_fv", {31'b0, fetch_valid}, 32'h0);
        chk("rst_src", {29'b0, pc_src}, {29'b0, SRC_HOLD});
        chk("rst_empty", {31'b0, ras_empty}, 32'h1);
        reset = 1'b0;
        #2;
        chk("boot_fv", {31'b0, fetch_valid}, 32'h0);
        idle();
        chk("run_fv", {31'b0, fetch_valid}, 32'h1);
        chk("run_pc0", pc, 32'h0);
        idle(); chk("seq_4", pc, 32'h4);
        idle(); chk("seq_8", pc, 32'h8);
        idle(); chk("seq_c", pc, 32'hc);

        // redirect beats stall, then plain stall holds
        drv(1, 0, 0, 1, 32'h40, 0, 0, 0, 0);
        chk("redir_pc", pc, 32'h40);
        chk("redir_src", {29'b0, pc_src}, {29'b0, SRC_REDIRECT});
        drv(1, 0, 0, 0, 32'h0, 0, 0, 0, 0);
        chk("stall_pc", pc, 32'h40);
        chk("stall_src", {29'b0, pc_src}, {29'b0, SRC_HOLD});

        // call/return pair
        drv(0, 0, 0, 1, 32'h10, 0, 0, 0, 0);
        drv(0, 0, 0, 1, 32'h80, 0, 0, 1, 0);
        idle();
        chk("pre_ret_pc", pc, 32'h84);
        drv(0, 0, 0, 0, 32'h0, 0, 0, 0, 1);
        chk("ret_pc", pc, RAS_ON ? 32'h14 : 32'h88);
        chk("ret_src", {29'b0, pc_src}, {29'b0, RAS_ON ? SRC_RAS : SRC_SEQ});
        chk("ret_empty", {31'b0, ras_empty}, 32'h1);

        // overflow: five calls into a four-deep stack, then five returns
        drv(0, 0, 0, 1, 32'h100, 0, 0, 0, 0);
        for (int i = 2; i <= 6; i++) drv(0, 0, 0, 1, 32'(i) << 8, 0, 0, 1, 0);
        chk("calls_pc", pc, 32'h600);
        if (RAS_ON) begin
            ret_exp[0] = 32'h504; ret_exp[1] = 32'h404; ret_exp[2] = 32'h304;
            ret_exp[3] = 32'h204; ret_exp[4] = 32'h208;
        end else begin
            for (int i = 0; i < 5; i++) ret_exp[i] = 32'h604 + 32'(4 * i);
        end
        for (int i = 0; i < 5; i++) begin
            drv(0, 0, 0, 0, 32'h0, 0, 0, 0, 1);
            chk("ovf_ret_pc", pc, ret_exp[i]);
        end
        chk("ovf_src", {29'b0, pc_src}, {29'b0, SRC_SEQ});
        chk("ovf_empty", {31'b0, ras_empty}, 32'h1);

        // trap beats redirect and call, flushes the stack
        drv(0, 0, 0, 1, 32'h300, 0, 0, 1, 0);
        drv(0, 0, 0, 1, 32'h400, 0, 0, 1, 0);
        chk("two_calls_empty", {31'b0, ras_empty}, RAS_ON ? 32'h0 : 32'h1);
        drv(0, 0, 0, 1, 32'h500, 1, 32'h200, 1, 0);
        chk("trap_pc", pc, 32'h200);
        chk("trap_src", {29'b0, pc_src}, {29'b0, SRC_TRAP});
        chk("trap_empty", {31'b0, ras_empty}, 32'h1);

        // halt for ten cycles with noise on the ignored inputs, then resume
        drv(0, 1, 0, 0, 32'h0, 0, 0, 0, 0);
        chk("halt_fv", {31'b0, fetch_valid}, 32'h0);
        for (int i = 0; i < 10; i++) begin
            drv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)),
                32'h900, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk("halt_pc", pc, 32'h200);
        end
        drv(0, 0, 1, 0, 32'h0, 0, 0, 0, 0);
        chk("resume_pc", pc, 32'h200);
        chk("resume_fv", {31'b0, fetch_valid}, 32'h1);
        idle();
        chk("resume_adv", pc, 32'h204);

        // trap leaves HALTED directly
        drv(0, 1, 0, 0, 32'h0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 32'h0, 1, 32'h300, 0, 0);
        chk("halt_trap_pc", pc, 32'h300);
        chk("halt_trap_fv", {31'b0, fetch_valid}, 32'h1);

        // misaligned target loaded as-is; increment wraps modulo 2^32
        drv(0, 0, 0, 1, 32'h302, 0, 0, 0, 0);
        chk("misal_pc", pc, 32'h302);
        chk("misal_flag", {31'b0, pc_misaligned}, 32'h1);
        drv(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        chk("wrap_p4", pc_plus4, 32'h0);
        idle();
        chk("wrap_pc", pc, 32'h0);

        // mixed random traffic against the model
        for (int i = 0; i < 300; i++) begin
            drv(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0),
                1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
                $urandom() & 32'hFFFF_FFFC, 1'($urandom_range(0, 15) == 0),
                $urandom() & 32'hFFFF_FFFC, 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 2) == 0));
        end

        // asynchronous reset between edges
        drv(0, 0, 1, 1, 32'h700, 0, 0, 0, 0);
        idle();
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("areset_pc", pc, 32'h0);
        chk("areset_fv", {31'b0, fetch_valid}, 32'h0);
        chk("areset_src", {29'b0, pc_src}, {29'b0, SRC_HOLD});
        chk("areset_empty", {31'b0, ras_empty}, 32'h1);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        idle();
        idle();
        chk("post_reset_pc", pc, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
